rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port arbiter for the 32×32 register file. Up to N writeback sources (ALU, load, mult/div) share the register file's single write port through valid/ready handshakes and round-robin arbitration. The winning request is registered and drives RegWrite/rc/dc for one cycle. Writes to register 0 are accepted but suppressed.

## Interface
- N, 3, number of writeback requesters (2..8)
- clk  in  1  rising-edge clock shared with the register file
- rst  in  1  synchronous, active-high reset
- hold  in  1  pipeline stall; blocks new grants while high
- req_valid  in  N  request i has a write pending
- req_addr  in  5·N  destination register for request i, slice [5i+4:5i]
- req_data  in  32·N  write data for request i, slice [32i+31:32i]
- req_ready  out  N  grant to request i (one-hot or zero), combinational
- RegWrite  out  1  register-file write enable, registered
- rc  out  5  register-file write address, registered
- dc  out  32  register-file write data, registered
- ra, rb  in  5 each  register-file read addresses (RF_WB_BYPASS_EN only)
- da_rf, db_rf  in  32 each  raw register-file read data (RF_WB_BYPASS_EN only)
- da, db  out  32 each  forwarded read data (RF_WB_BYPASS_EN only)

## Operation
- State: priority pointer ptr, range 0..N-1, reset value 0. Output registers RegWrite, rc, dc reset to 0.
- Grant (combinational):
  - If rst or hold is high, req_ready = 0.
  - Otherwise req_ready[i] = 1 for the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod N.
  - req_ready is at most one-hot and never asserts for a requester with req_valid=0.
- Transfer: a request is accepted on the edge where req_valid[i] & req_ready[i] = 1. The requester holds valid/addr/data stable until accepted and may drop them after that edge.
- Pointer update on an accept of request i: ptr <= (i+1) mod N, wrapping from N-1 to 0. With no accept, ptr holds.
- Output stage, every edge:
  - RegWrite <= accept & (addr ≠ 0).
  - rc <= accepted addr, and dc <= accepted data, whenever an accept occurs; otherwise rc and dc hold.
  - A write to register 0 is consumed (ready returned) but produces RegWrite=0.
- Backpressure: the output stage drains every cycle and the register file has no stall, so the block sustains one accept per cycle.
- Fairness: with all N requesters continuously valid, each is granted exactly once in every N consecutive cycles.

## Timing
- Grant latency is 0: req_ready follows req_valid/ptr/hold in the same cycle.
- Accept at edge k → RegWrite/rc/dc valid during cycle k..k+1 → register file written at edge k+1. Data is visible on raw reads after edge k+1.
- hold asserted in cycle k: no accept at edge k, and RegWrite=0 after edge k. A write already in the output stage still completes at edge k.
- rst mid-operation: at the next edge RegWrite, rc, dc and ptr go to 0. An in-flight output-stage write completes only if it was already presented before that edge. A pending request is not accepted while rst is high.

## Configuration
- RF_WB_BYPASS_EN defined:
  - da = (ra≠0 & RegWrite & rc==ra) ? dc : da_rf.
  - db is defined the same way for rb.
  - ra=0 always yields da=0, and rb=0 always yields db=0.
  - This closes the one-cycle write-visibility gap for decode-stage reads.
- RF_WB_BYPASS_EN undefined: ra, rb, da_rf, db_rf, da and db are not present, and there is no forwarding logic.

## Test plan
- Reset, then single request: req_valid=3'b010, addr=5, data=32'hDEAD_BEEF → req_ready=3'b010 the same cycle. The next cycle shows RegWrite=1, rc=5, dc=DEADBEEF, and ptr=2.
- All three valid for 6 cycles starting from ptr=0 → grants 0,1,2,0,1,2, with one RegWrite per cycle carrying each requester's addr/data.
- Register-0 write: req 0 addr=0, data=7 → req_ready[0]=1 and the next cycle shows RegWrite=0. ptr still advances to 1.
- hold=1 for 2 cycles with req 2 valid → req_ready=0 and RegWrite=0 throughout. After hold drops, req 2 is granted immediately and its write appears one cycle later.
- rst asserted with ptr=2 and req 1 valid → after the edge RegWrite=0, rc=0, dc=0, ptr=0 and req 1 is not accepted. After rst drops, req 1 is granted.
- With RF_WB_BYPASS_EN, output stage holding rc=9, dc=123, ra=9, rb=0, da_rf=55 → da=123 and db=0. The next cycle, with RegWrite=0, gives da=da_rf.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter for the register-file write port. Writes to
//            r0 are consumed without asserting RegWrite. Defining
//            RF_WB_BYPASS_EN adds write-to-read forwarding on ports a and b.
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [N-1:0]    req_valid,
    input  logic [5*N-1:0]  req_addr,
    input  logic [32*N-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            RegWrite,
    output logic [4:0]      rc,
    output logic [31:0]     dc
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [4:0]      ra,
    input  logic [4:0]      rb,
    input  logic [31:0]     da_rf,
    input  logic [31:0]     db_rf,
    output logic [31:0]     da,
    output logic [31:0]     db
`endif
);

    localparam int               PTR_W      = $clog2(N);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(N - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_sel;
    logic [N-1:0]     w_grant;
    logic             w_accept;
    logic [4:0]       w_addr;
    logic [31:0]      w_data;

    // Scan requesters starting at r_ptr; the first valid one wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = '0;
        w_sel    = '0;
        w_accept = 1'b0;
        if (!rst && !hold) begin
            for (int off = 0; off < N; off++) begin
                idx = int'(r_ptr) + off;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!w_accept && req_valid[idx]) begin
                    w_grant[idx] = 1'b1;
                    w_sel        = PTR_W'(idx);
                    w_accept     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr[5*i +: 5];
                w_data = req_data[32*i +: 32];
            end
        end
    end

    assign w_ptr_next = (w_sel == C_PTR_LAST) ? '0 : w_sel + 1'b1;
    assign req_ready  = w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            RegWrite <= 1'b0;
            rc       <= '0;
            dc       <= '0;
        end else begin
            RegWrite <= w_accept && (w_addr != 5'd0);
            if (w_accept) begin
                r_ptr <= w_ptr_next;
                rc    <= w_addr;
                dc    <= w_data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // r0 reads as zero regardless of what the register file returns.
    assign da = (ra == 5'd0) ? 32'd0 : ((RegWrite && rc == ra) ? dc : da_rf);
    assign db = (rb == 5'd0) ? 32'd0 : ((RegWrite && rc == rb) ? dc : db_rf);
`endif

endmodule
`default_nettype wire
